// File: rtl/mips_pkg.sv
// mips_pkg: shared mult/div FSM encoding and default latencies for the MIPS pipeline.
package mips_pkg;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int DIV_CYCLES_DEF = 32;
    typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_t;
endpackage

// File: rtl/hazard_control_unit_if.sv
// hazard_control_unit_if: pipeline hazard inputs and stall/flush/mult-div status outputs.
interface hazard_control_unit_if;
    logic       id_ex_mem_read;
    logic [4:0] id_ex_instr_rt;
    logic [4:0] if_id_instr_rs;
    logic [4:0] if_id_instr_rt;
    logic       id_uses_rt;
    logic       ex_branch_taken;
    logic       md_start;
    logic       md_is_div;
    logic       id_hilo_use;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       md_busy;
    logic       md_done;
    modport master (
        output id_ex_mem_read, id_ex_instr_rt, if_id_instr_rs, if_id_instr_rt, id_uses_rt,
               ex_branch_taken, md_start, md_is_div, id_hilo_use,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done
    );
    modport slave (
        input  id_ex_mem_read, id_ex_instr_rt, if_id_instr_rs, if_id_instr_rt, id_uses_rt,
               ex_branch_taken, md_start, md_is_div, id_hilo_use,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, md_busy, md_done
    );
endinterface

// File: rtl/md_cycle_counter.sv
// md_cycle_counter: tracks mult/div occupancy; busy for N cycles after start, done on the last.
module md_cycle_counter
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);
    localparam int CW = $clog2(DIV_CYCLES + 1);
    localparam logic [CW-1:0] MUL_LD = CW'(MUL_CYCLES);
    localparam logic [CW-1:0] DIV_LD = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] ONE    = CW'(1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // start is ignored while running; the upstream hilo stall keeps a second op out of EX
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == MD_IDLE) begin
            if (start) begin
                cnt_d   = is_div ? DIV_LD : MUL_LD;
                state_d = MD_RUN;
            end
        end else begin
            cnt_d   = (cnt_q == '0) ? '0 : cnt_q - ONE;
            state_d = (cnt_q <= ONE) ? MD_IDLE : MD_RUN;
        end
    end

    assign busy = (state_q == MD_RUN);
    assign done = busy && (cnt_q == ONE);
endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use and hi/lo stall detection plus branch flush for the 5-stage pipeline.
module hazard_control_unit
    import mips_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input logic                  clk,
    input logic                  rst,
    hazard_control_unit_if.slave hz
);
    logic load_use, md_hazard, stall, busy, done;

    md_cycle_counter #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_md (
        .clk   (clk),
        .rst   (rst),
        .start (hz.md_start),
        .is_div(hz.md_is_div),
        .busy  (busy),
        .done  (done)
    );

    assign load_use  = hz.id_ex_mem_read && (hz.id_ex_instr_rt != 5'd0) &&
                       ((hz.id_ex_instr_rt == hz.if_id_instr_rs) ||
                        (hz.id_uses_rt && (hz.id_ex_instr_rt == hz.if_id_instr_rt)));
    assign md_hazard = busy && hz.id_hilo_use;
    // a taken branch squashes the stalled instruction anyway; reset forces the idle pattern
    assign stall     = (load_use || md_hazard) && !hz.ex_branch_taken && !rst;

    assign hz.pc_write    = !stall;
    assign hz.if_id_write = !stall;
    assign hz.if_id_flush = hz.ex_branch_taken && !rst;
    assign hz.id_ex_flush = (stall || hz.ex_branch_taken) && !rst;
    assign hz.md_busy     = busy;
    assign hz.md_done     = done;
endmodule

// File: tb/tb_hazard_control_unit.sv
// tb_hazard_control_unit: directed scenarios plus random traffic against a cycle-window model.
module tb_hazard_control_unit;
    localparam int MUL = 4;
    localparam int DIV = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    hazard_control_unit_if hif();

    hazard_control_unit #(.MUL_CYCLES(MUL), .DIV_CYCLES(DIV)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // model: an accepted start at edge cyc makes the unit busy for cycle numbers [s, s+n)
    int cyc = 0;
    int s   = -1000;
    int n   = 1;

    always @(posedge clk or posedge rst) begin
        if (rst) s <= -1000;
        else begin
            cyc <= cyc + 1;
            if (hif.md_start && !(cyc >= s && cyc < s + n)) begin
                s <= cyc + 1;
                n <= hif.md_is_div ? DIV : MUL;
            end
        end
    end

    bit         pin_en = 1'b0;
    logic [5:0] pin_vec = '0;
    string      pin_name = "";

    task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %b expected %b", nm, $time, act, exp);
        end
    endtask

    logic       e_busy, e_done, e_lu, e_stall;
    logic [5:0] act_v, exp_v;

    always @(negedge clk) begin
        e_busy  = !rst && cyc >= s && cyc < s + n;
        e_done  = e_busy && cyc == s + n - 1;
        e_lu    = hif.id_ex_mem_read && hif.id_ex_instr_rt != 0 &&
                  (hif.id_ex_instr_rt == hif.if_id_instr_rs ||
                   (hif.id_uses_rt && hif.id_ex_instr_rt == hif.if_id_instr_rt));
        e_stall = !rst && !hif.ex_branch_taken && (e_lu || (e_busy && hif.id_hilo_use));
        exp_v   = {!e_stall, !e_stall, !rst && hif.ex_branch_taken,
                   !rst && (e_stall || hif.ex_branch_taken), e_busy, e_done};
        act_v   = {hif.pc_write, hif.if_id_write, hif.if_id_flush, hif.id_ex_flush,
                   hif.md_busy, hif.md_done};
        chk("pc_write",    {5'd0, act_v[5]}, {5'd0, exp_v[5]});
        chk("if_id_write", {5'd0, act_v[4]}, {5'd0, exp_v[4]});
        chk("if_id_flush", {5'd0, act_v[3]}, {5'd0, exp_v[3]});
        chk("id_ex_flush", {5'd0, act_v[2]}, {5'd0, exp_v[2]});
        chk("md_busy",     {5'd0, act_v[1]}, {5'd0, exp_v[1]});
        chk("md_done",     {5'd0, act_v[0]}, {5'd0, exp_v[0]});
        if (pin_en) chk(pin_name, act_v, pin_vec);
    end

    task automatic idle();
        hif.id_ex_mem_read  = 1'b0;
        hif.id_ex_instr_rt  = 5'd0;
        hif.if_id_instr_rs  = 5'd0;
        hif.if_id_instr_rt  = 5'd0;
        hif.id_uses_rt      = 1'b0;
        hif.ex_branch_taken = 1'b0;
        hif.md_start        = 1'b0;
        hif.md_is_div       = 1'b0;
        hif.id_hilo_use     = 1'b0;
    endtask

    task automatic tick(input bit p, input logic [5:0] v, input string nm);
        pin_en   = p;
        pin_vec  = v;
        pin_name = nm;
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic load(input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rt);
        hif.id_ex_mem_read = 1'b1;
        hif.id_ex_instr_rt = ert;
        hif.if_id_instr_rs = rs;
        hif.if_id_instr_rt = rt;
        hif.id_uses_rt     = use_rt;
    endtask

    initial begin
        idle();
        @(posedge clk);
        #1;
        tick(1, 6'b110000, "rst_hold");
        rst = 1'b0;
        tick(1, 6'b110000, "post_rst");
        load(5'd5, 5'd5, 5'd0, 1'b0);
        tick(1, 6'b000100, "s1_stall");
        idle();
        tick(1, 6'b110000, "s1_clear");
        load(5'd0, 5'd0, 5'd0, 1'b1);
        tick(1, 6'b110000, "s2_r0");
        load(5'd7, 5'd3, 5'd7, 1'b0);
        tick(1, 6'b110000, "s2_rt_unused");
        hif.id_uses_rt = 1'b1;
        tick(1, 6'b000100, "s2_rt_used");
        load(5'd5, 5'd5, 5'd0, 1'b0);
        hif.ex_branch_taken = 1'b1;
        tick(1, 6'b111100, "s4_branch");
        idle();
        hif.md_start  = 1'b1;
        hif.md_is_div = 1'b1;
        tick(1, 6'b110000, "s3_start");
        idle();
        hif.id_hilo_use = 1'b1;
        for (int k = 1; k <= 33; k++)
            tick(1, k < 32 ? 6'b000110 : (k == 32 ? 6'b000111 : 6'b110000), "s3_div_mfhi");
        idle();
        hif.md_start = 1'b1;
        tick(1, 6'b110000, "s6_start");
        for (int k = 1; k <= 5; k++) begin
            hif.md_start = (k == 2 || k == 3);
            tick(1, k < 4 ? 6'b110010 : (k == 4 ? 6'b110011 : 6'b110000), "s6_restart");
        end
        idle();
        hif.md_start  = 1'b1;
        hif.md_is_div = 1'b1;
        tick(1, 6'b110000, "s5_start");
        idle();
        for (int k = 1; k <= 9; k++) tick(1, 6'b110010, "s5_busy");
        rst = 1'b1;
        tick(1, 6'b110000, "s5_async_rst");
        rst = 1'b0;
        tick(1, 6'b110000, "s5_after_rst");
        hif.md_start = 1'b1;
        tick(1, 6'b110000, "s5_mul_start");
        idle();
        for (int k = 1; k <= 5; k++)
            tick(1, k < 4 ? 6'b110010 : (k == 4 ? 6'b110011 : 6'b110000), "s5_mul");
        for (int k = 0; k < 600; k++) begin
            rst                 = ($urandom_range(0, 79) == 0);
            hif.id_ex_mem_read  = $urandom_range(0, 1) == 1;
            hif.id_ex_instr_rt  = 5'($urandom_range(0, 3));
            hif.if_id_instr_rs  = 5'($urandom_range(0, 3));
            hif.if_id_instr_rt  = 5'($urandom_range(0, 3));
            hif.id_uses_rt      = $urandom_range(0, 1) == 1;
            hif.ex_branch_taken = $urandom_range(0, 5) == 0;
            hif.md_start        = $urandom_range(0, 7) == 0;
            hif.md_is_div       = $urandom_range(0, 2) == 0;
            hif.id_hilo_use     = $urandom_range(0, 1) == 1;
            tick(0, 6'b0, "");
        end
        rst = 1'b0;
        idle();
        tick(0, 6'b0, "");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_control_unit.md
HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 4, meaning the number of busy cycles for a multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning the number of busy cycles for a divide.
REQ-003 clk  input  1  single pipeline clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 id_ex_mem_read  input  1  the instruction in EX is a load.
REQ-006 id_ex_instr_rt  input  5  destination register of the load in EX.
REQ-007 if_id_instr_rs  input  5  rs field of the instruction in ID.
REQ-008 if_id_instr_rt  input  5  rt field of the instruction in ID.
REQ-009 id_uses_rt  input  1  the ID instruction reads rt as a source.
REQ-010 ex_branch_taken  input  1  branch or jump resolved taken in EX.
REQ-011 md_start  input  1  mult/div issuing from EX this cycle.
REQ-012 md_is_div  input  1  qualifies md_start: 1 means divide, 0 means multiply.
REQ-013 id_hilo_use  input  1  ID instruction is mfhi, mflo, mult or div.
REQ-014 pc_write  output  1  PC update enable.
REQ-015 if_id_write  output  1  IF/ID register enable.
REQ-016 if_id_flush  output  1  zero the IF/ID register.
REQ-017 id_ex_flush  output  1  insert a bubble into ID/EX (control bits cleared).
REQ-018 md_busy  output  1  mult/div unit occupied.
REQ-019 md_done  output  1  one-cycle pulse on the final busy cycle.

Function
REQ-020 load_use SHALL be id_ex_mem_read AND id_ex_instr_rt!=0 AND (id_ex_instr_rt==if_id_instr_rs OR (id_uses_rt AND id_ex_instr_rt==if_id_instr_rt)).
REQ-021 md_hazard SHALL be md_busy AND id_hilo_use.
REQ-022 stall SHALL be (load_use OR md_hazard) AND NOT ex_branch_taken.
REQ-023 pc_write and if_id_write SHALL each be NOT stall.
REQ-024 id_ex_flush SHALL be stall OR ex_branch_taken.
REQ-025 if_id_flush SHALL be ex_branch_taken, which overrides every stall in the same cycle.
REQ-026 All outputs except md_busy and md_done SHALL be combinational, with zero-cycle latency.
REQ-027 Load-use SHALL cost exactly one bubble, because the hazard clears once the load leaves EX.
REQ-028 The FSM SHALL have two states: MD_IDLE and MD_RUN.
REQ-029 In MD_IDLE, md_start SHALL load the counter with DIV_CYCLES if md_is_div is 1, otherwise MUL_CYCLES, and go to MD_RUN.
REQ-030 In MD_RUN, the counter SHALL decrement each cycle; at count 1 the FSM SHALL return to MD_IDLE.
REQ-031 md_busy SHALL be 1 exactly in MD_RUN, which is N consecutive cycles starting the cycle after the md_start edge.
REQ-032 md_done SHALL be 1 in MD_RUN when the count equals 1.
REQ-033 md_start in MD_RUN SHALL be ignored. The upstream guarantee is md_hazard, which prevents a second mult/div from reaching EX.
REQ-034 The counter SHALL be $clog2(DIV_CYCLES+1) bits wide and SHALL never wrap below 0.
REQ-035 MUL_CYCLES and DIV_CYCLES SHALL each be at least 1; with N=1, md_busy and md_done are high for a single cycle.
REQ-036 ex_branch_taken SHALL NOT abort an in-flight mult/div, which is already past EX.

Reset
REQ-037 rst SHALL immediately force MD_IDLE and counter 0 without waiting for clk.
REQ-038 During and after reset, the outputs SHALL be pc_write=1, if_id_write=1, if_id_flush=0, id_ex_flush=0, md_busy=0, md_done=0.
REQ-039 Reset asserted mid-divide SHALL drop md_busy in the same cycle, with no md_done pulse.

Structure
REQ-040 MD state encoding and the default MUL_CYCLES and DIV_CYCLES constants SHALL live in shared package mips_pkg.
REQ-041 The counter plus FSM SHALL be a sub-module md_cycle_counter (ports clk, rst, start, is_div, busy, done); the hazard equations stay in the top module.

Verification
REQ-042 Scenario 1: load with rt=5 in EX, ID rs=5 → pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle, then all 1/1/0.
REQ-043 Scenario 2: load with rt=0 in EX, ID rs=0 → no stall; load with rt=7, ID rt=7, id_uses_rt=0 → no stall.
REQ-044 Scenario 3: md_start with md_is_div=1 → md_busy high 32 cycles, md_done high only on cycle 32; mfhi in ID during busy stalls until the cycle after md_done.
REQ-045 Scenario 4: load-use hazard and ex_branch_taken in the same cycle → pc_write=1, if_id_flush=1, id_ex_flush=1.
REQ-046 Scenario 5: rst asserted asynchronously at cycle 10 of a divide → md_busy=0 before the next edge; a new multiply then gives 4 busy cycles.
REQ-047 Scenario 6: md_start pulsed again during MD_RUN → the count is unaffected and total busy cycles stay at N.
